// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The state enum, header/word byte counts and the default memory depth live here.
package instr_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        BODY,
        DONE,
        ERROR
    } state_t;

    localparam int HDR_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;
    localparam int DEF_ADDR_W     = 15;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Little-endian 4-byte assembler shared by the header and body phases.
// o_word is complete, including the current byte, in the cycle o_word_valid is high.
module byte_packer
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    localparam int CNT_W   = $clog2(BYTES_PER_WORD);
    localparam int SHIFT_W = 8 * (BYTES_PER_WORD - 1);

    logic [CNT_W-1:0]   r_cnt;
    logic [SHIFT_W-1:0] r_shift;
    logic               w_last;

    assign w_last = (r_cnt == CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_valid) begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Bytes enter at the top so the first one ends up in the low byte.
    always_ff @(posedge clk) begin
        if (i_valid) begin
            r_shift <= {i_byte, r_shift[SHIFT_W-1:8]};
        end
    end

    assign o_word       = {i_byte, r_shift};
    assign o_word_valid = i_valid && w_last;

endmodule

// File: rtl/instr_loader.sv
// Boot-time program loader: parses a word-count header from a byte stream and
// writes the following little-endian words to instruction memory from address 0.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W:0]   r_index;
    logic [31:0]       r_count;
    logic              r_rx_ready, r_we, r_busy, r_done, r_err;
    logic [31:0]       r_waddr, r_wdata;
    logic              w_accept, w_start, w_word_valid, w_last_word;
    logic [31:0]       w_word;

    assign w_accept    = rx_valid && r_rx_ready;
    assign w_last_word = (32'(r_index) + 32'd1) == r_count;

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_start),
        .i_valid      (w_accept),
        .i_byte       (rx_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    w_start = 1'b1;
                    w_next  = HEADER;
                end
            end
            HEADER: begin
                if (w_word_valid) begin
                    if (w_word == '0)        w_next = DONE;
                    else if (w_word > DEPTH) w_next = ERROR;
                    else                     w_next = BODY;
                end
            end
            BODY: begin
                if (w_word_valid && w_last_word) w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_index    <= '0;
            r_count    <= '0;
            r_rx_ready <= 1'b0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_rx_ready <= (w_next == HEADER) || (w_next == BODY);
            r_busy     <= (w_next == HEADER) || (w_next == BODY);
            r_done     <= (w_next == DONE);
            r_err      <= (w_next == ERROR);
            r_we       <= (r_state == BODY) && w_word_valid;
            if (r_state == HEADER && w_word_valid) begin
                r_count <= w_word;
            end
            if (w_start) begin
                r_index <= '0;
            end else if (r_state == BODY && w_word_valid) begin
                r_index <= r_index + 1'b1;
                r_waddr <= {{(30 - ADDR_W){1'b0}}, r_index[ADDR_W-1:0], 2'b00};
                r_wdata <= w_word;
            end
        end
    end

    assign rx_ready = r_rx_ready;
    assign we       = r_we;
    assign waddr    = r_waddr;
    assign wdata    = r_wdata;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule
